// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl_if
// Description : Handshake and data bundle for the bit-serial adder.
//               master : requester (drives start/a/b/cin, observes results)
//               slave  : adder (observes request, drives busy/done/sum/cout/ovf)
// Signals     : start, a[WIDTH], b[WIDTH], cin   -> request side
//               busy, done, sum[WIDTH], cout, ovf -> result side
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface : serial_adder_ctrl_if
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder computing a+b+cin with a single reused
//               1-bit full adder, LSB first, one bit per clock.
//               A request is accepted in IDLE; WIDTH cycles of RUN follow,
//               then a one-cycle DONE with a done pulse. Results are
//               registered and only change at the completion edge.
// Ports       : clk   - clock, rising edge active
//               reset - synchronous active-high reset
//               bus   - serial_adder_ctrl_if.slave (start/a/b/cin in,
//                       busy/done/sum/cout/ovf out)
// Parameters  : WIDTH - operand/result width, 2..32
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  wire logic            clk,
    input  wire logic            reset,
    serial_adder_ctrl_if.slave   bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // The single full adder shared by every bit position.
    logic             fa_sum_d;
    logic             fa_carry_d;
    logic [WIDTH-1:0] res_d;
    logic             last_bit_d;

    assign fa_sum_d   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign fa_carry_d = (a_sh_q[0] & b_sh_q[0]) |
                        (a_sh_q[0] & carry_q)   |
                        (b_sh_q[0] & carry_q);

    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign res_d      = {fa_sum_d, res_q[WIDTH-1:1]};
    assign last_bit_d = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end

                S_RUN: begin
                    a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
                    res_q   <= res_d;
                    carry_q <= fa_carry_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_bit_d) begin
                        // carry_q here is the carry into the MSB.
                        sum_q   <= res_d;
                        cout_q  <= fa_carry_d;
                        ovf_q   <= carry_q ^ fa_carry_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule : serial_adder_ctrl
`default_nettype wire
